// File: rtl/bcd_counter_arbiter.sv
`default_nettype none
// =============================================================================
// bcd_counter_arbiter : round-robin arbitration of two requesters onto a shared
// two-digit BCD counter. Define BCD_SAT_EN to saturate INC/DEC at 99/00.
// Revision: 1.0
// =============================================================================
module bcd_counter_arbiter #(
  parameter bit RR_INIT  = 1'b0,
  parameter int LOAD_MAX = 99
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Req0_Valid,
  input  logic [1:0] i_Req0_Op,
  input  logic [6:0] i_Req0_Data,
  output logic       o_Req0_Ready,
  input  logic       i_Req1_Valid,
  input  logic [1:0] i_Req1_Op,
  input  logic [6:0] i_Req1_Data,
  output logic       o_Req1_Ready,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones,
  output logic       o_Update,
  output logic [1:0] o_Grant,
  output logic       o_Load_Err
);

  localparam logic [1:0] c_OP_INC  = 2'b00;
  localparam logic [1:0] c_OP_DEC  = 2'b01;
  localparam logic [1:0] c_OP_LOAD = 2'b10;
  localparam logic [1:0] c_OP_CLR  = 2'b11;

`ifdef BCD_SAT_EN
  localparam bit c_SAT = 1'b1;
`else
  localparam bit c_SAT = 1'b0;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t     r_state;
  logic       r_pri;
  logic [1:0] r_op;
  logic [6:0] r_data;
  logic       r_id;

  logic       w_idle;
  logic       w_hs0;
  logic       w_hs1;
  logic       w_ld_ok;
  logic [3:0] w_tens_nxt;
  logic [3:0] w_ones_nxt;

  // Ready is held low during reset as well as in EXEC.
  assign w_idle       = i_Rst_L && (r_state == S_IDLE);
  assign o_Req0_Ready = w_idle && i_Req0_Valid && (!i_Req1_Valid || !r_pri);
  assign o_Req1_Ready = w_idle && i_Req1_Valid && (!i_Req0_Valid ||  r_pri);
  assign w_hs0        = i_Req0_Valid && o_Req0_Ready;
  assign w_hs1        = i_Req1_Valid && o_Req1_Ready;
  assign w_ld_ok      = (int'(r_data) <= LOAD_MAX);

  always_comb begin
    w_tens_nxt = o_Tens;
    w_ones_nxt = o_Ones;
    case (r_op)
      c_OP_INC: begin
        if (o_Ones != 4'd9) begin
          w_ones_nxt = o_Ones + 4'd1;
        end else if (o_Tens != 4'd9) begin
          w_ones_nxt = 4'd0;
          w_tens_nxt = o_Tens + 4'd1;
        end else if (!c_SAT) begin
          w_ones_nxt = 4'd0;
          w_tens_nxt = 4'd0;
        end
      end
      c_OP_DEC: begin
        if (o_Ones != 4'd0) begin
          w_ones_nxt = o_Ones - 4'd1;
        end else if (o_Tens != 4'd0) begin
          w_ones_nxt = 4'd9;
          w_tens_nxt = o_Tens - 4'd1;
        end else if (!c_SAT) begin
          w_ones_nxt = 4'd9;
          w_tens_nxt = 4'd9;
        end
      end
      c_OP_LOAD: begin
        if (w_ld_ok) begin
          w_tens_nxt = 4'(r_data / 7'd10);
          w_ones_nxt = 4'(r_data % 7'd10);
        end
      end
      c_OP_CLR: begin
        w_tens_nxt = 4'd0;
        w_ones_nxt = 4'd0;
      end
      default: begin
        w_tens_nxt = o_Tens;
        w_ones_nxt = o_Ones;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state    <= S_IDLE;
      r_pri      <= RR_INIT;
      r_op       <= c_OP_INC;
      r_data     <= 7'd0;
      r_id       <= 1'b0;
      o_Tens     <= 4'd0;
      o_Ones     <= 4'd0;
      o_Update   <= 1'b0;
      o_Grant    <= 2'b00;
      o_Load_Err <= 1'b0;
    end else begin
      o_Update   <= 1'b0;
      o_Load_Err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hs0 || w_hs1) begin
            r_op    <= w_hs1 ? i_Req1_Op   : i_Req0_Op;
            r_data  <= w_hs1 ? i_Req1_Data : i_Req0_Data;
            r_id    <= w_hs1;
            r_pri   <= !w_hs1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          o_Tens  <= w_tens_nxt;
          o_Ones  <= w_ones_nxt;
          o_Grant <= r_id ? 2'b10 : 2'b01;
          if ((r_op == c_OP_LOAD) && !w_ld_ok) begin
            o_Load_Err <= 1'b1;
          end else begin
            o_Update <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
